// File: rtl/fetch_stage_pkg.sv
// Shared constants and IF/ID payload type for the P7 fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned EXC_W    = 5;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_TOP     = 32'h0000_4FFC;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    localparam logic [31:0]      ERET_WORD = 32'h4200_0018;
    localparam logic [EXC_W-1:0] EXC_NONE  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL  = 5'd4;

    typedef struct packed {
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pc_add4;
        logic [EXC_W-1:0] exc_code;
        logic             bd;
        logic             valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_cti_decode.sv
// Flags branch/jump instructions (the ones that own a delay slot).
module cti_decode
    import fetch_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_cti
);

    logic [5:0] opcode;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr[31:26];
    assign rt            = instr[20:16];
    assign funct         = instr[5:0];
    assign unused_fields = ^{instr[25:21], instr[15:6]};

    always_comb begin
        is_cti = 1'b0;
        unique case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL: is_cti = 1'b1;
            OP_REGIMM:  is_cti = (rt == RT_BLTZ) || (rt == RT_BGEZ);
            OP_SPECIAL: is_cti = (funct == FN_JR) || (funct == FN_JALR);
            default:    is_cti = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// PC register and IF/ID pipeline register with AdEL detection, delay-slot
// tracking and ERET squash.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] EXC_VECTOR = fetch_stage_pkg::EXC_VECTOR,
    parameter logic [31:0] IM_BASE    = fetch_stage_pkg::IM_BASE,
    parameter logic [31:0] IM_TOP     = fetch_stage_pkg::IM_TOP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   npc,
    input  logic              stall,
    input  logic              exc_req,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   imem_addr,
    output logic [XLEN-1:0]   if_pc_add4,
    output logic [XLEN-1:0]   id_instr,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_pc_add4,
    output logic [EXC_W-1:0]  id_exc_code,
    output logic              id_bd,
    output logic              id_valid
);

    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          ifid_q, ifid_d;

    logic [XLEN-1:0] pc_add4;
    logic [XLEN-1:0] fetched;
    logic            adel;
    logic            eret_id;
    logic            id_is_cti;

    cti_decode u_cti_decode (
        .instr  (ifid_q.instr),
        .is_cti (id_is_cti)
    );

    // Fetch-side checks on the current PC
    always_comb begin
        pc_add4 = pc_q + XLEN'(4);
        adel    = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_TOP);
        fetched = adel ? '0 : imem_rdata;
        eret_id = ifid_q.valid && (ifid_q.instr == ERET_WORD);
    end

    // Edge priority: exception, stall, ERET squash, normal advance
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (exc_req) begin
            pc_d   = EXC_VECTOR;
            ifid_d = '0;
        end else if (stall) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
        end else if (eret_id) begin
            pc_d   = npc;
            ifid_d = '0;
        end else begin
            pc_d            = npc;
            ifid_d.instr    = fetched;
            ifid_d.pc       = pc_q;
            ifid_d.pc_add4  = pc_add4;
            ifid_d.exc_code = adel ? EXC_ADEL : EXC_NONE;
            ifid_d.bd       = id_is_cti && ifid_q.valid;
            ifid_d.valid    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            ifid_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_pc_add4  = pc_add4;
    assign id_instr    = ifid_q.instr;
    assign id_pc       = ifid_q.pc;
    assign id_pc_add4  = ifid_q.pc_add4;
    assign id_exc_code = ifid_q.exc_code;
    assign id_bd       = ifid_q.bd;
    assign id_valid    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        exc_req;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] if_pc_add4;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_add4;
    logic [4:0]  id_exc_code;
    logic        id_bd;
    logic        id_valid;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .npc         (npc),
        .stall       (stall),
        .exc_req     (exc_req),
        .imem_rdata  (imem_rdata),
        .imem_addr   (imem_addr),
        .if_pc_add4  (if_pc_add4),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_add4  (id_pc_add4),
        .id_exc_code (id_exc_code),
        .id_bd       (id_bd),
        .id_valid    (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] npc;
        logic        stall;
        logic        exc;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_bd;
        logic [4:0]  e_exc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [31:0] n, input logic s, input logic e,
                                input logic [31:0] rd, input logic [31:0] ea,
                                input logic [31:0] ep, input logic [31:0] ei,
                                input logic ev, input logic eb, input logic [4:0] ex);
        vec_t v;
        v.npc = n; v.stall = s; v.exc = e; v.rdata = rd;
        v.e_addr = ea; v.e_pc = ep; v.e_instr = ei;
        v.e_valid = ev; v.e_bd = eb; v.e_exc = ex;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_id(input int idx, input logic [31:0] ea, input logic [31:0] ep,
                          input logic [31:0] ei, input logic ev, input logic eb,
                          input logic [4:0] ex);
        logic [31:0] ea4, epa4;
        ea4  = ea + 32'd4;
        epa4 = ev ? ep + 32'd4 : 32'd0;
        chk("imem_addr",   idx, imem_addr,   ea);
        chk("if_pc_add4",  idx, if_pc_add4,  ea4);
        chk("id_pc",       idx, id_pc,       ep);
        chk("id_instr",    idx, id_instr,    ei);
        chk("id_pc_add4",  idx, id_pc_add4,  epa4);
        chk("id_valid",    idx, 32'(id_valid),    32'(ev));
        chk("id_bd",       idx, 32'(id_bd),       32'(eb));
        chk("id_exc_code", idx, 32'(id_exc_code), 32'(ex));
    endtask

    initial begin
        //            npc           stl  exc  rdata         addr          id_pc         id_instr      v  bd exc
        vecs[0]  = mk(32'h3004,     0,   0,   32'h2008_0001, 32'h3004,     32'h3000,     32'h2008_0001, 1, 0, 0);
        vecs[1]  = mk(32'h3008,     0,   0,   32'h1000_0003, 32'h3008,     32'h3004,     32'h1000_0003, 1, 0, 0);
        vecs[2]  = mk(32'h3010,     0,   0,   32'h0000_0000, 32'h3010,     32'h3008,     32'h0000_0000, 1, 1, 0);
        vecs[3]  = mk(32'h3014,     0,   0,   32'h2009_0002, 32'h3014,     32'h3010,     32'h2009_0002, 1, 0, 0);
        vecs[4]  = mk(32'h3018,     1,   0,   32'h200A_0003, 32'h3014,     32'h3010,     32'h2009_0002, 1, 0, 0);
        vecs[5]  = mk(32'h3018,     1,   0,   32'h200A_0003, 32'h3014,     32'h3010,     32'h2009_0002, 1, 0, 0);
        vecs[6]  = mk(32'h3018,     0,   0,   32'h200A_0003, 32'h3018,     32'h3014,     32'h200A_0003, 1, 0, 0);
        vecs[7]  = mk(32'h301C,     0,   0,   32'h1400_0002, 32'h301C,     32'h3018,     32'h1400_0002, 1, 0, 0);
        vecs[8]  = mk(32'h3020,     1,   0,   32'h2010_0007, 32'h301C,     32'h3018,     32'h1400_0002, 1, 0, 0);
        vecs[9]  = mk(32'h3020,     0,   0,   32'h2010_0007, 32'h3020,     32'h301C,     32'h2010_0007, 1, 1, 0);
        vecs[10] = mk(32'h3024,     1,   1,   32'h2011_0008, 32'h4180,     32'h0,        32'h0,         0, 0, 0);
        vecs[11] = mk(32'h4184,     0,   0,   32'h0800_0C00, 32'h4184,     32'h4180,     32'h0800_0C00, 1, 0, 0);
        vecs[12] = mk(32'h4188,     0,   0,   32'h4200_0018, 32'h4188,     32'h4184,     32'h4200_0018, 1, 1, 0);
        vecs[13] = mk(32'h3040,     0,   0,   32'h2012_0009, 32'h3040,     32'h0,        32'h0,         0, 0, 0);
        vecs[14] = mk(32'h3044,     0,   0,   32'h2013_000A, 32'h3044,     32'h3040,     32'h2013_000A, 1, 0, 0);
        vecs[15] = mk(32'h3002,     0,   0,   32'h2014_000B, 32'h3002,     32'h3044,     32'h2014_000B, 1, 0, 0);
        vecs[16] = mk(32'h5000,     0,   0,   32'h2015_000C, 32'h5000,     32'h3002,     32'h0,         1, 0, 4);
        vecs[17] = mk(32'h5004,     0,   0,   32'h2016_000D, 32'h5004,     32'h5000,     32'h0,         1, 0, 4);
        vecs[18] = mk(32'hFFFF_FFFC, 0,  0,   32'h2017_000E, 32'hFFFF_FFFC, 32'h5004,    32'h0,         1, 0, 4);
        vecs[19] = mk(32'h3000,     0,   0,   32'h2018_000F, 32'h3000,     32'hFFFF_FFFC, 32'h0,        1, 0, 4);

        reset      = 1'b0;
        npc        = 32'h0;
        stall      = 1'b0;
        exc_req    = 1'b0;
        imem_rdata = 32'h0;
        #12;
        reset = 1'b1;
        #1;
        chk_id(-1, 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);

        for (int i = 0; i < NV; i++) begin
            npc        = vecs[i].npc;
            stall      = vecs[i].stall;
            exc_req    = vecs[i].exc;
            imem_rdata = vecs[i].rdata;
            @(posedge clk);
            #1;
            chk_id(i, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_instr,
                   vecs[i].e_valid, vecs[i].e_bd, vecs[i].e_exc);
        end

        // Mid-stream reset takes effect without a clock edge
        npc        = 32'h3004;
        stall      = 1'b0;
        exc_req    = 1'b0;
        imem_rdata = 32'h2008_0001;
        #1;
        reset = 1'b0;
        #1;
        chk_id(100, 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_id(101, 32'h3004, 32'h3000, 32'h2008_0001, 1'b1, 1'b0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register plus IF/ID pipeline register of the P7 MIPS microsystem. Sits directly upstream of the next-PC logic and feeds it.
- Each cycle it loads the NPC result, or the exception vector, into the PC, presents the PC to instruction memory, and registers the fetched word into the ID stage.
- Tracks delay-slot membership, detects fetch address errors, and squashes the word fetched behind ERET.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, handler entry on exception.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_TOP, 32'h0000_4FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- npc  in  32  next PC from NPC (branch, jump, ERET and PC+4 already resolved).
- stall  in  1  hazard stall: hold PC and IF/ID.
- exc_req  in  1  CP0 takes an exception this cycle.
- imem_rdata  in  32  instruction word at imem_addr (combinational read).
- imem_addr  out  32  current PC.
- if_pc_add4  out  32  PC+4 of the fetch stage, to NPC.
- id_instr  out  32  registered instruction.
- id_pc  out  32  registered PC.
- id_pc_add4  out  32  registered PC+4 (NPC PCAdd4 input).
- id_exc_code  out  5  0 = none, 4 = AdEL.
- id_bd  out  1  ID instruction sits in a branch/jump delay slot.
- id_valid  out  1  0 = bubble.

Behaviour:
- Reset (asynchronous, active-low):
  - pc = RESET_PC.
  - id_instr, id_pc, id_pc_add4 = 0; id_exc_code = 0; id_bd = 0; id_valid = 0.
- Combinational outputs: imem_addr = pc; if_pc_add4 = pc + 4, modulo 2^32.
- Fetch check: adel = (pc[1:0] != 0) OR pc < IM_BASE OR pc > IM_TOP. The fetched word is 32'h0 when adel is set, else imem_rdata.
- Control-transfer decode of id_instr (cti): beq, bne, blez, bgtz, bltz, bgez, j, jal, jr, jalr.
- ERET decode: eret_id = id_valid AND id_instr == 32'h4200_0018.
- Priority at each rising edge, first match wins:
  1. exc_req: pc <= EXC_VECTOR; IF/ID flushed (instr 0, pc 0, pc_add4 0, exc 0, bd 0, valid 0). exc_req overrides stall.
  2. stall: pc and every IF/ID field hold.
  3. eret_id: pc <= npc; IF/ID flushed as in 1. ERET has no delay slot.
  4. Otherwise: pc <= npc; id_instr <= fetched word; id_pc <= pc; id_pc_add4 <= pc+4; id_exc_code <= adel ? 4 : 0; id_bd <= cti(id_instr) AND id_valid; id_valid <= 1.
- Latency: a word fetched in cycle N appears on id_* at N+1. A new PC is visible on imem_addr one cycle after its npc is sampled.
- Misaligned or out-of-range PC:
  - The PC still advances to npc; no hold.
  - The bubble carries exc_code 4 with id_valid = 1 so CP0 reports it when the instruction reaches the commit point.
- Branch and stall together: stall wins. id_instr holds, so cti and bd are re-evaluated identically the next cycle.
- A bubble (id_valid = 0) never marks the following slot as bd.
- Wrap-around: pc = 32'hFFFF_FFFC gives if_pc_add4 = 0, and adel is flagged by the range check.
- Reset mid-operation: all state returns to the reset values immediately, independent of clk.

Decomposition:
- Shared package holds: MIPS opcode/funct constants (BEQ 6'b000100, BNE 000101, BLEZ 000110, BGTZ 000111, REGIMM 000001, J 000010, JAL 000011, SPECIAL 000000, JR 001000, JALR 001001), ERET_WORD 32'h4200_0018, EXC_ADEL 5'd4, RESET_PC, EXC_VECTOR.
- One sub-module, cti_decode: combinational 32-bit instruction in, is_cti out. It is reusable by the NPC and CP0 logic.

Test Plan:
- Reset release, npc = pc+4, imem returns 32'h2008_0001 at 0x3000:
  - cycle 1: id_pc = 0x3000, id_instr = 32'h2008_0001, id_valid = 1.
  - imem_addr then steps 0x3004, 0x3008.
- Branch then delay slot: id_instr = beq (32'h1000_0003) at 0x3000, npc = 0x3010:
  - next cycle: id_pc = 0x3004 with id_bd = 1; imem_addr = 0x3010.
  - following instruction: id_bd = 0.
- Stall for 2 cycles mid-stream: pc and all id_* outputs are unchanged for exactly 2 edges, then the stream resumes without loss or duplication.
- exc_req asserted together with stall at pc = 0x3020:
  - next cycle: imem_addr = 0x4180, id_valid = 0, id_bd = 0.
- ERET in ID (32'h4200_0018), npc = EPC 0x3040:
  - next cycle: imem_addr = 0x3040, IF/ID bubble (valid 0).
  - the word fetched at ERET's pc+4 never appears on id_instr.
- npc = 0x3002, then npc = 0x5000:
  - each produces id_exc_code = 4, id_instr = 0, id_valid = 1.
  - assert reset mid-stream: pc = 0x3000 and id_valid = 0 before the next edge.
